// File: rtl/psr_exception_sequencer_pkg.sv
// Shared constants for the PSR exception sequencer: widths, mode encodings,
// exception indices (index order is priority order), vectors and FSM states.
package psr_exception_sequencer_pkg;

  localparam int WordWidth = 32;
  localparam int NumExc    = 7;

  localparam logic [4:0] MODE_USER = 5'b10000;
  localparam logic [4:0] MODE_FIQ  = 5'b10001;
  localparam logic [4:0] MODE_IRQ  = 5'b10010;
  localparam logic [4:0] MODE_SVC  = 5'b10011;
  localparam logic [4:0] MODE_ABT  = 5'b10111;
  localparam logic [4:0] MODE_UND  = 5'b11011;
  localparam logic [4:0] MODE_SYS  = 5'b11111;

  // Lower index wins arbitration.
  localparam logic [2:0] EXC_RESET = 3'd0;
  localparam logic [2:0] EXC_DABT  = 3'd1;
  localparam logic [2:0] EXC_FIQ   = 3'd2;
  localparam logic [2:0] EXC_IRQ   = 3'd3;
  localparam logic [2:0] EXC_PABT  = 3'd4;
  localparam logic [2:0] EXC_UNDEF = 3'd5;
  localparam logic [2:0] EXC_SWI   = 3'd6;

  localparam logic [WordWidth-1:0] VEC_RESET = 32'h0000_0000;
  localparam logic [WordWidth-1:0] VEC_UNDEF = 32'h0000_0004;
  localparam logic [WordWidth-1:0] VEC_SWI   = 32'h0000_0008;
  localparam logic [WordWidth-1:0] VEC_PABT  = 32'h0000_000C;
  localparam logic [WordWidth-1:0] VEC_DABT  = 32'h0000_0010;
  localparam logic [WordWidth-1:0] VEC_IRQ   = 32'h0000_0018;
  localparam logic [WordWidth-1:0] VEC_FIQ   = 32'h0000_001C;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SAVE   = 2'd1,
    ST_SWITCH = 2'd2,
    ST_VECTOR = 2'd3
  } state_e;

  function automatic logic [4:0] exc_mode(input logic [2:0] cause);
    case (cause)
      EXC_DABT, EXC_PABT: return MODE_ABT;
      EXC_FIQ:            return MODE_FIQ;
      EXC_IRQ:            return MODE_IRQ;
      EXC_UNDEF:          return MODE_UND;
      default:            return MODE_SVC;
    endcase
  endfunction

  function automatic logic [WordWidth-1:0] exc_vector(input logic [2:0] cause);
    case (cause)
      EXC_DABT:  return VEC_DABT;
      EXC_FIQ:   return VEC_FIQ;
      EXC_IRQ:   return VEC_IRQ;
      EXC_PABT:  return VEC_PABT;
      EXC_UNDEF: return VEC_UNDEF;
      EXC_SWI:   return VEC_SWI;
      default:   return VEC_RESET;
    endcase
  endfunction

  // Replace the bytes of base selected by mask ({f,s,x,c}) with bytes of src.
  function automatic logic [WordWidth-1:0] byte_merge(input logic [WordWidth-1:0] base,
                                                      input logic [WordWidth-1:0] src,
                                                      input logic [3:0] mask);
    logic [WordWidth-1:0] r;
    r = base;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = src[8*b +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/psr_exception_sequencer_priority.sv
// Combinational exception arbiter: applies the CPSR I/F masks, then picks the
// lowest-index (highest-priority) live request and looks up its mode and vector.
module psr_exception_priority
  import psr_exception_sequencer_pkg::*;
(
  input  logic [NumExc-1:0]    req_i,
  input  logic                 irq_mask_i,
  input  logic                 fiq_mask_i,
  output logic                 valid_o,
  output logic [2:0]           cause_o,
  output logic [4:0]           mode_o,
  output logic [WordWidth-1:0] vector_o
);

  logic [NumExc-1:0] live;

  // Mask IRQ/FIQ, then scan downward so the lowest live index is left standing.
  always_comb begin
    live          = req_i;
    live[EXC_IRQ] = req_i[EXC_IRQ] & ~irq_mask_i;
    live[EXC_FIQ] = req_i[EXC_FIQ] & ~fiq_mask_i;
    valid_o       = 1'b0;
    cause_o       = EXC_RESET;
    for (int i = NumExc - 1; i >= 0; i--) begin
      if (live[i]) begin
        valid_o = 1'b1;
        cause_o = 3'(i);
      end
    end
    mode_o   = exc_mode(cause_o);
    vector_o = exc_vector(cause_o);
  end

endmodule

// File: rtl/psr_exception_sequencer.sv
// Sequencer for all CPSR/SPSR writes: applies MSR in IDLE combinationally and
// runs the save / switch / vector sequence for exception entry.
//
// state     | meaning
// ST_IDLE   | MSR applied this cycle, else accept highest unmasked request
// ST_SAVE   | write saved CPSR into SPSR of target mode
// ST_SWITCH | write CPSR with new mode, I set, T cleared, F per cause
// ST_VECTOR | flush and redirect fetch until acknowledged
module psr_exception_sequencer
  import psr_exception_sequencer_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NumExc-1:0]    in_ExceptionRequest,
  input  logic [WordWidth-1:0] in_CPSR_Fresh,
  input  logic                 in_MSRWriteEnable,
  input  logic                 in_MSRToSPSR,
  input  logic [3:0]           in_MSRFieldMask,
  input  logic [WordWidth-1:0] in_MSRValue,
  input  logic                 in_VectorAck,
  output logic                 out_CPSRWriteEnable,
  output logic [WordWidth-1:0] out_CPSRValue,
  output logic                 out_SPSRWriteEnable,
  output logic [4:0]           out_SPSRMode,
  output logic [WordWidth-1:0] out_SPSRValue,
  output logic                 out_Stall,
  output logic                 out_Flush,
  output logic [WordWidth-1:0] out_VectorAddress,
  output logic                 out_Busy
);

  state_e               state_q;
  logic [2:0]           cause_q;
  logic [4:0]           mode_q;
  logic [WordWidth-1:0] vec_q;
  logic [WordWidth-1:0] saved_q;
  logic                 spsr_we_q;
  logic                 cpsr_we_q;
  logic                 flush_q;

  logic                 exc_valid;
  logic [2:0]           exc_cause;
  logic [4:0]           exc_mode_w;
  logic [WordWidth-1:0] exc_vec;

  logic [4:0]           cur_mode;
  logic                 msr_act;
  logic                 msr_cpsr_we;
  logic                 msr_spsr_we;
  logic [3:0]           cpsr_mask;
  logic                 force_f;
  logic [WordWidth-1:0] switch_val;

  psr_exception_priority u_priority (
    .req_i      (in_ExceptionRequest),
    .irq_mask_i (in_CPSR_Fresh[7]),
    .fiq_mask_i (in_CPSR_Fresh[6]),
    .valid_o    (exc_valid),
    .cause_o    (exc_cause),
    .mode_o     (exc_mode_w),
    .vector_o   (exc_vec)
  );

  // MSR decode: only honoured in IDLE; user mode may only touch the flags byte,
  // and user/system modes have no SPSR to write.
  always_comb begin
    cur_mode    = in_CPSR_Fresh[4:0];
    msr_act     = (state_q == ST_IDLE) && in_MSRWriteEnable;
    msr_cpsr_we = msr_act && !in_MSRToSPSR;
    msr_spsr_we = msr_act && in_MSRToSPSR &&
                  (cur_mode != MODE_USER) && (cur_mode != MODE_SYS);
    cpsr_mask   = (cur_mode == MODE_USER) ? {in_MSRFieldMask[3], 3'b000} : in_MSRFieldMask;
    force_f     = (cause_q == EXC_FIQ) || (cause_q == EXC_RESET);
    switch_val  = {saved_q[WordWidth-1:8], 1'b1, force_f | saved_q[6], 1'b0, mode_q};
  end

  // Entry sequence FSM with registered write/flush strobes; soft reset skips SAVE.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cause_q   <= EXC_RESET;
      mode_q    <= '0;
      vec_q     <= '0;
      saved_q   <= '0;
      spsr_we_q <= 1'b0;
      cpsr_we_q <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      spsr_we_q <= 1'b0;
      cpsr_we_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!in_MSRWriteEnable && exc_valid) begin
            cause_q <= exc_cause;
            mode_q  <= exc_mode_w;
            vec_q   <= exc_vec;
            saved_q <= in_CPSR_Fresh;
            if (exc_cause == EXC_RESET) begin
              state_q   <= ST_SWITCH;
              cpsr_we_q <= 1'b1;
            end else begin
              state_q   <= ST_SAVE;
              spsr_we_q <= 1'b1;
            end
          end
        end
        ST_SAVE: begin
          state_q   <= ST_SWITCH;
          cpsr_we_q <= 1'b1;
        end
        ST_SWITCH: begin
          state_q <= ST_VECTOR;
          flush_q <= 1'b1;
        end
        ST_VECTOR: begin
          if (in_VectorAck) begin
            state_q <= ST_IDLE;
            flush_q <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Output merge: sequence strobes and MSR strobes are mutually exclusive.
  always_comb begin
    out_CPSRWriteEnable = cpsr_we_q | msr_cpsr_we;
    out_CPSRValue       = cpsr_we_q   ? switch_val :
                          msr_cpsr_we ? byte_merge(in_CPSR_Fresh, in_MSRValue, cpsr_mask) : '0;
    out_SPSRWriteEnable = spsr_we_q | msr_spsr_we;
    out_SPSRMode        = spsr_we_q ? mode_q : (msr_spsr_we ? cur_mode : '0);
    out_SPSRValue       = spsr_we_q   ? saved_q :
                          msr_spsr_we ? byte_merge('0, in_MSRValue, in_MSRFieldMask) : '0;
    out_Flush           = flush_q;
    out_VectorAddress   = flush_q ? vec_q : '0;
    out_Busy            = (state_q != ST_IDLE);
    out_Stall           = out_Busy;
  end

endmodule

// File: tb/tb_psr_exception_sequencer.sv
// Bench for psr_exception_sequencer: directed scenarios plus a randomized run
// checked against a cycle-count based reference model.
module tb_psr_exception_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic [6:0]  in_ExceptionRequest;
  logic [31:0] in_CPSR_Fresh;
  logic        in_MSRWriteEnable;
  logic        in_MSRToSPSR;
  logic [3:0]  in_MSRFieldMask;
  logic [31:0] in_MSRValue;
  logic        in_VectorAck;
  logic        out_CPSRWriteEnable;
  logic [31:0] out_CPSRValue;
  logic        out_SPSRWriteEnable;
  logic [4:0]  out_SPSRMode;
  logic [31:0] out_SPSRValue;
  logic        out_Stall;
  logic        out_Flush;
  logic [31:0] out_VectorAddress;
  logic        out_Busy;

  int errors = 0;
  int checks = 0;

  psr_exception_sequencer dut (
    .clock               (clock),
    .reset               (reset),
    .in_ExceptionRequest (in_ExceptionRequest),
    .in_CPSR_Fresh       (in_CPSR_Fresh),
    .in_MSRWriteEnable   (in_MSRWriteEnable),
    .in_MSRToSPSR        (in_MSRToSPSR),
    .in_MSRFieldMask     (in_MSRFieldMask),
    .in_MSRValue         (in_MSRValue),
    .in_VectorAck        (in_VectorAck),
    .out_CPSRWriteEnable (out_CPSRWriteEnable),
    .out_CPSRValue       (out_CPSRValue),
    .out_SPSRWriteEnable (out_SPSRWriteEnable),
    .out_SPSRMode        (out_SPSRMode),
    .out_SPSRValue       (out_SPSRValue),
    .out_Stall           (out_Stall),
    .out_Flush           (out_Flush),
    .out_VectorAddress   (out_VectorAddress),
    .out_Busy            (out_Busy)
  );

  always #5 clock = ~clock;

  wire [105:0] obs = {out_CPSRWriteEnable, out_CPSRValue, out_SPSRWriteEnable, out_SPSRMode,
                      out_SPSRValue, out_Stall, out_Flush, out_VectorAddress, out_Busy};

  // Reference tables indexed by exception number (0 = highest priority).
  logic [4:0]  mode_tab [0:6] = '{5'h13, 5'h17, 5'h11, 5'h12, 5'h17, 5'h1B, 5'h13};
  logic [31:0] vec_tab  [0:6] = '{32'h00, 32'h10, 32'h1C, 32'h18, 32'h0C, 32'h04, 32'h08};

  // Reference model state: k = cycles into the entry sequence (0 = idle).
  int          k_m;
  int          c_m;
  logic [31:0] saved_m;
  logic [31:0] cpsr_m;

  function automatic logic [105:0] pack(logic cwe, logic [31:0] cval, logic swe, logic [4:0] smode,
                                        logic [31:0] sval, logic stall, logic flush,
                                        logic [31:0] vec, logic busy);
    return {cwe, cval, swe, smode, sval, stall, flush, vec, busy};
  endfunction

  function automatic logic [31:0] merge(logic [31:0] base, logic [31:0] src, logic [3:0] mask);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++) if (mask[b]) r[8*b +: 8] = src[8*b +: 8];
    return r;
  endfunction

  function automatic int winner(logic [6:0] req, logic [31:0] cpsr);
    for (int i = 0; i < 7; i++) begin
      if (req[i] && !(i == 2 && cpsr[6]) && !(i == 3 && cpsr[7])) return i;
    end
    return -1;
  endfunction

  function automatic logic [105:0] model_expect();
    logic [4:0]  md;
    logic [3:0]  m;
    logic        f;
    md = cpsr_m[4:0];
    if (k_m == 0) begin
      if (in_MSRWriteEnable) begin
        if (!in_MSRToSPSR) begin
          m = (md == 5'h10) ? (in_MSRFieldMask & 4'b1000) : in_MSRFieldMask;
          return pack(1'b1, merge(cpsr_m, in_MSRValue, m), 1'b0, 5'h0, 32'h0,
                      1'b0, 1'b0, 32'h0, 1'b0);
        end else if (md != 5'h10 && md != 5'h1F) begin
          return pack(1'b0, 32'h0, 1'b1, md, merge(32'h0, in_MSRValue, in_MSRFieldMask),
                      1'b0, 1'b0, 32'h0, 1'b0);
        end
      end
      return '0;
    end else if (k_m == 1) begin
      return pack(1'b0, 32'h0, 1'b1, mode_tab[c_m], saved_m, 1'b1, 1'b0, 32'h0, 1'b1);
    end else if (k_m == 2) begin
      f = (c_m == 0 || c_m == 2) ? 1'b1 : saved_m[6];
      return pack(1'b1, {saved_m[31:8], 1'b1, f, 1'b0, mode_tab[c_m]}, 1'b0, 5'h0, 32'h0,
                  1'b1, 1'b0, 32'h0, 1'b1);
    end
    return pack(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, vec_tab[c_m], 1'b1);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_quiet();
    in_ExceptionRequest = '0;
    in_MSRWriteEnable   = 1'b0;
    in_MSRToSPSR        = 1'b0;
    in_MSRFieldMask     = '0;
    in_MSRValue         = '0;
    in_VectorAck        = 1'b0;
  endtask

  task automatic test_reset();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'h13;
    reset = 1'b1;
    tick();
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_outputs: got %h want %h", obs, e); end
    reset = 1'b0;
    tick();
    #3;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL reset_release_idle: got %h want %h", obs, e); end
    tick();
  endtask

  task automatic test_irq_entry();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'h10;
    in_ExceptionRequest = 7'b0001000;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL irq_n_idle: got %h want %h", obs, e); end
    tick();
    in_ExceptionRequest = '0;
    #3;
    e = pack(1'b0, 32'h0, 1'b1, 5'h12, 32'h10, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL irq_save: got %h want %h", obs, e); end
    tick();
    #3;
    e = pack(1'b1, 32'h92, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL irq_switch: got %h want %h", obs, e); end
    tick();
    in_CPSR_Fresh = 32'h92;
    in_VectorAck = 1'b1;
    #3;
    e = pack(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 32'h18, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL irq_vector: got %h want %h", obs, e); end
    tick();
    in_VectorAck = 1'b0;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL irq_back_idle: got %h want %h", obs, e); end
    tick();
  endtask

  task automatic test_masking_priority();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'hD3;
    in_ExceptionRequest = 7'b0001100;
    for (int i = 0; i < 3; i++) begin
      #3;
      e = '0;
      checks++;
      if (obs !== e) begin errors++; $display("FAIL masked_no_action: got %h want %h", obs, e); end
      tick();
    end
    in_MSRWriteEnable = 1'b1;
    in_MSRFieldMask = 4'b0001;
    in_MSRValue = 32'h13;
    #3;
    e = pack(1'b1, 32'h13, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL unmask_msr: got %h want %h", obs, e); end
    tick();
    in_MSRWriteEnable = 1'b0;
    in_CPSR_Fresh = 32'h13;
    tick();
    #3;
    e = pack(1'b0, 32'h0, 1'b1, 5'h11, 32'h13, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fiq_first_save: got %h want %h", obs, e); end
    tick();
    #3;
    e = pack(1'b1, 32'hD1, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fiq_switch: got %h want %h", obs, e); end
    tick();
    in_CPSR_Fresh = 32'hD1;
    in_VectorAck = 1'b1;
    #3;
    e = pack(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 32'h1C, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL fiq_vector: got %h want %h", obs, e); end
    tick();
    in_VectorAck = 1'b0;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL irq_remasked_idle: got %h want %h", obs, e); end
    tick();
    in_ExceptionRequest = '0;
    tick();
  endtask

  task automatic test_msr_dabt();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'h13;
    in_ExceptionRequest = 7'b0000010;
    in_MSRWriteEnable = 1'b1;
    in_MSRFieldMask = 4'b1000;
    in_MSRValue = 32'hF000_0000;
    #3;
    e = pack(1'b1, 32'hF000_0013, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL msr_with_dabt: got %h want %h", obs, e); end
    tick();
    in_MSRWriteEnable = 1'b0;
    in_CPSR_Fresh = 32'hF000_0013;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL dabt_deferred: got %h want %h", obs, e); end
    tick();
    in_ExceptionRequest = '0;
    #3;
    e = pack(1'b0, 32'h0, 1'b1, 5'h17, 32'hF000_0013, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL dabt_save: got %h want %h", obs, e); end
    tick();
    #3;
    e = pack(1'b1, 32'hF000_0097, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL dabt_switch: got %h want %h", obs, e); end
    tick();
    in_VectorAck = 1'b1;
    #3;
    e = pack(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 32'h10, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL dabt_vector: got %h want %h", obs, e); end
    tick();
    in_VectorAck = 1'b0;
    tick();
  endtask

  task automatic test_user_msr();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'h10;
    in_MSRWriteEnable = 1'b1;
    in_MSRFieldMask = 4'hF;
    in_MSRValue = 32'hF000_00D3;
    #3;
    e = pack(1'b1, 32'hF000_0010, 1'b0, 5'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL user_msr_cpsr: got %h want %h", obs, e); end
    tick();
    in_MSRToSPSR = 1'b1;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL user_msr_spsr_ignored: got %h want %h", obs, e); end
    tick();
    in_CPSR_Fresh = 32'h13;
    in_MSRFieldMask = 4'b1001;
    in_MSRValue = 32'hAABB_CCDD;
    #3;
    e = pack(1'b0, 32'h0, 1'b1, 5'h13, 32'hAA00_00DD, 1'b0, 1'b0, 32'h0, 1'b0);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL svc_msr_spsr: got %h want %h", obs, e); end
    tick();
    drive_quiet();
    tick();
  endtask

  task automatic test_soft_reset();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'h10;
    in_ExceptionRequest = 7'b1111111;
    tick();
    in_ExceptionRequest = '0;
    #3;
    e = pack(1'b1, 32'hD3, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL softrst_switch: got %h want %h", obs, e); end
    tick();
    in_CPSR_Fresh = 32'hD3;
    in_VectorAck = 1'b1;
    #3;
    e = pack(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL softrst_vector: got %h want %h", obs, e); end
    tick();
    in_VectorAck = 1'b0;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL softrst_idle: got %h want %h", obs, e); end
    tick();
  endtask

  task automatic test_mid_reset();
    logic [105:0] e;
    drive_quiet();
    in_CPSR_Fresh = 32'h13;
    in_ExceptionRequest = 7'b1000000;
    tick();
    in_ExceptionRequest = '0;
    tick();
    #3;
    e = pack(1'b1, 32'h93, 1'b0, 5'h0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b1);
    checks++;
    if (obs !== e) begin errors++; $display("FAIL swi_switch: got %h want %h", obs, e); end
    #1;
    reset = 1'b1;
    #1;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mid_reset_outputs: got %h want %h", obs, e); end
    tick();
    reset = 1'b0;
    tick();
    #3;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL mid_reset_idle: got %h want %h", obs, e); end
    tick();
    in_ExceptionRequest = 7'b0001000;
    tick();
    in_ExceptionRequest = '0;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      #3;
      e = pack(1'b0, 32'h0, 1'b0, 5'h0, 32'h0, 1'b1, 1'b1, 32'h18, 1'b1);
      checks++;
      if (obs !== e) begin errors++; $display("FAIL vector_hold: got %h want %h", obs, e); end
      tick();
    end
    in_VectorAck = 1'b1;
    tick();
    in_VectorAck = 1'b0;
    #3;
    e = '0;
    checks++;
    if (obs !== e) begin errors++; $display("FAIL vector_hold_release: got %h want %h", obs, e); end
    tick();
  endtask

  task automatic test_random();
    logic [105:0] e;
    int w;
    drive_quiet();
    k_m = 0;
    c_m = 0;
    saved_m = '0;
    cpsr_m = 32'h0000_00D3;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      in_CPSR_Fresh       = cpsr_m;
      in_ExceptionRequest = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'h0;
      in_MSRWriteEnable   = ($urandom_range(0, 3) == 0);
      in_MSRToSPSR        = 1'($urandom);
      in_MSRFieldMask     = 4'($urandom);
      in_MSRValue         = $urandom;
      in_VectorAck        = 1'($urandom);
      #3;
      e = model_expect();
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL random_cycle_%0d: got %h want %h", cyc, obs, e);
      end
      if (e[105]) cpsr_m = e[104:73];
      if (k_m == 0) begin
        if (!in_MSRWriteEnable) begin
          w = winner(in_ExceptionRequest, in_CPSR_Fresh);
          if (w >= 0) begin
            c_m = w;
            saved_m = in_CPSR_Fresh;
            k_m = (w == 0) ? 2 : 1;
          end
        end
      end else if (k_m < 3) begin
        k_m++;
      end else if (in_VectorAck) begin
        k_m = 0;
      end
      tick();
    end
    drive_quiet();
  endtask

  initial begin
    test_reset();
    test_irq_entry();
    test_masking_priority();
    test_msr_dabt();
    test_user_msr();
    test_soft_reset();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psr_exception_sequencer.md
# psr_exception_sequencer

Sequences all architectural writes to CPSR and the banked SPSRs. It sits beside the pipeline's CPSR forwarding logic and consumes the fresh CPSR value. It arbitrates between MSR writes retiring from WB and exception entry. For exception entry it runs a multi-cycle sequence: save CPSR to the target SPSR, switch mode and mask bits, then redirect fetch to the vector. It stalls the pipeline for the whole sequence.

## Interface
- WordWidth, 32, data width of PSR and address buses
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- in_ExceptionRequest  in  7  level requests: [0] soft reset, [1] data abort, [2] FIQ, [3] IRQ, [4] prefetch abort, [5] undefined, [6] SWI
- in_CPSR_Fresh  in  WordWidth  current forwarded CPSR
- in_MSRWriteEnable  in  1  MSR retiring in WB this cycle
- in_MSRToSPSR  in  1  1 = target SPSR of current mode, 0 = CPSR
- in_MSRFieldMask  in  4  field mask {f,s,x,c}, one bit per byte [31:24]..[7:0]
- in_MSRValue  in  WordWidth  MSR source operand
- in_VectorAck  in  1  fetch has accepted the redirect
- out_CPSRWriteEnable  out  1  write out_CPSRValue to CPSR this cycle
- out_CPSRValue  out  WordWidth
- out_SPSRWriteEnable  out  1
- out_SPSRMode  out  5  bank select, mode encoding
- out_SPSRValue  out  WordWidth
- out_Stall  out  1  freeze IF..WB
- out_Flush  out  1  flush pipeline and load out_VectorAddress
- out_VectorAddress  out  WordWidth
- out_Busy  out  1  state != IDLE

## Operation
- States: IDLE, SAVE, SWITCH, VECTOR.
- **IDLE, MSR active:**
  - MSR is applied combinationally in the same cycle.
  - CPSR target: value = in_CPSR_Fresh with masked bytes replaced by in_MSRValue bytes. In user mode (mode 10000) only the f byte is honoured.
  - SPSR target: out_SPSRMode = current mode, value = in_MSRValue masked bytes merged over zero. Ignored (no write) in user and system modes.
  - Exception requests are not accepted in an MSR cycle.
- **IDLE, no MSR:**
  - Pick the highest unmasked request. Priority: reset > dabt > FIQ > IRQ > pabt > undef > SWI.
  - IRQ is masked by CPSR[7]; FIQ is masked by CPSR[6].
  - On a winner, latch the cause, target mode, vector and in_CPSR_Fresh (saved).
  - Next state is SAVE, or SWITCH when the cause is soft reset.
- **Mode/vector map:**
  - reset: SVC 10011, vector 0x00
  - undef: UND 11011, vector 0x04
  - SWI: SVC, vector 0x08
  - pabt: ABT 10111, vector 0x0C
  - dabt: ABT, vector 0x10
  - IRQ: IRQ 10010, vector 0x18
  - FIQ: FIQ 10001, vector 0x1C
- **SAVE:** out_SPSRWriteEnable=1, out_SPSRMode = target mode, out_SPSRValue = saved. Next state SWITCH.
- **SWITCH:** out_CPSRWriteEnable=1, out_CPSRValue = {saved[31:8], I=1, F, T=0, target mode}. F = 1 for FIQ/reset, else saved[6]. Next state VECTOR.
- **VECTOR:** out_Flush=1, out_VectorAddress = vector. Hold until in_VectorAck=1, then go to IDLE.
- **MSR outside IDLE:** in_MSRWriteEnable is ignored (WB is stalled).
- Requests are sampled only in IDLE. A request still asserted on return to IDLE is re-evaluated against the new CPSR masks.

## Timing
- **Reset values:** state IDLE; all write enables, out_Stall, out_Flush and out_Busy = 0; value/address outputs = 0.
- MSR: zero latency, combinational in the IDLE cycle.
- Exception: request seen in IDLE at cycle N gives SAVE at N+1, SWITCH at N+2, VECTOR from N+3.
- Minimum out_Stall length is 3 cycles (2 for soft reset).
- out_Stall = 1 in SAVE, SWITCH and VECTOR; out_Flush = 1 only in VECTOR.
- in_VectorAck is evaluated only in VECTOR. An ack in the first VECTOR cycle returns to IDLE at N+4.
- All state, cause, vector and saved-CPSR registers are asynchronously cleared by reset. Reset mid-sequence aborts it with no further writes.

## Structure
- Shared defines/package:
  - WordWidth
  - mode encodings MODE_USER, MODE_FIQ, MODE_IRQ, MODE_SVC, MODE_ABT, MODE_UND, MODE_SYS
  - exception index constants
  - vector offsets
  - state encodings
- One sub-module: psr_exception_priority. Combinational; takes request vector and CPSR I/F bits; outputs valid, cause index, target mode and vector.

## Test plan
- **IRQ entry:** CPSR=0x00000010, IRQ raised → SPSR[IRQ]=0x10 at N+1; CPSR=0x00000092 at N+2; flush to 0x18 at N+3; ack → IDLE at N+4.
- **Masking and priority:**
  - CPSR=0x000000D3 with IRQ and FIQ raised → no action.
  - Clear I/F via MSR (mask c, value 0x13) → FIQ taken first, CPSR=0x000000D1, vector 0x1C.
- **Simultaneous MSR + dabt in IDLE:** MSR CPSR flags 0xF0000000 written that cycle; dabt starts next cycle; SPSR[ABT] = 0xF00000xx.
- **User MSR:** mode 0x10, mask 0xF, value 0xF00000D3 → CPSR = 0xF0000010. SPSR MSR in user → no write.
- **Soft reset:** no SPSR write; CPSR mode 0x13 with I=F=1; vector 0x00.
- **Mid-sequence reset:** reset asserted in SWITCH → all outputs 0 immediately, IDLE after release; held in VECTOR with no ack → out_Flush stays 1.
